// File: rtl/demux_pkg.sv
// Shared constants and slot state type for the 1:4 stream demultiplexer.
package demux_pkg;

  localparam logic        MODE_STEER = 1'b0;
  localparam logic        MODE_RR    = 1'b1;
  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned SEL_W      = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with an EMPTY/FULL state and valid/ready drain.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         drain_ready,
  output logic         valid,
  output logic [W-1:0] data
);

  slot_state_e state;

  // A load wins over a drain, so drain+fill in one cycle keeps the slot FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SLOT_EMPTY;
      data  <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: begin
          if (load) begin
            state <= SLOT_FULL;
            data  <= load_data;
          end
        end
        SLOT_FULL: begin
          if (load) begin
            data <= load_data;
          end else if (drain_ready) begin
            state <= SLOT_EMPTY;
          end
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

  assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux4n_stream.sv
// Registered 1:4 stream demultiplexer, steered by in_sel or distributed round-robin.
module demux4n_stream
  import demux_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_sel,
  input  logic         mode,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [W-1:0] out_data0,
  output logic [W-1:0] out_data1,
  output logic [W-1:0] out_data2,
  output logic [W-1:0] out_data3,
  output logic [1:0]   rr_ptr
);

  logic [SEL_W-1:0]  dst;
  logic              xfer;
  logic [NUM_CH-1:0] load;
  logic [W-1:0]      slot_data [NUM_CH];

  assign dst      = (mode == MODE_RR) ? rr_ptr : in_sel;
  assign in_ready = !out_valid[dst] || out_ready[dst];
  assign xfer     = in_valid && in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    assign load[k] = xfer && (dst == SEL_W'(k));

    demux_slot #(.W(W)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (load[k]),
      .load_data  (in_data),
      .drain_ready(out_ready[k]),
      .valid      (out_valid[k]),
      .data       (slot_data[k])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

  // Pointer only moves on an accepted round-robin word, so a busy target stalls in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer && (mode == MODE_RR)) begin
      rr_ptr <= rr_ptr + SEL_W'(1);
    end
  end

endmodule
